// File: rtl/mat_tx_streamer.sv
// mat_tx_streamer
//   Reads a ROWS x COLS matrix from a synchronous memory in row-major order
//   and streams every element over a UART 8N1 line, most significant byte
//   first. Bytes of one element go out back-to-back. An abort stops the
//   stream at the next byte boundary.
//
//   Optional feature: define MAT_TX_ROW_DELIM_EN to append byte 0x0A after
//   the last element of each row.
//
// Ports
//   clk_i          sole clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        level, sampled only in IDLE
//   abort_i        level, stops the stream at the next byte boundary
//   rd_en_o        one-cycle memory read strobe per element
//   rd_addr_o      element address, row-major
//   rd_data_i      memory data, valid one cycle after rd_en_o
//   tx_data_o      UART serial line, idle high
//   busy_o         high from start acceptance until FINISH
//   done_o         one-cycle pulse when a stream ends (complete or aborted)
//   elem_count_o   elements fully transmitted in the current stream
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | rd_en_o high for the current index
// WAIT_RD | memory returns data; captured into the element register
// LOAD    | MS byte of the element moved into the byte shifter
// SEND    | serialising element bytes
// NEXT    | element done; count it and advance or finish
// DELIM   | serialising the row delimiter (feature builds only)
// FINISH  | done pulse, back to IDLE
module mat_tx_streamer #(
  parameter int ROWS         = 2,
  parameter int COLS         = 2,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 6,
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              tx_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] elem_count_o
);

  localparam int                NBYTES    = DATA_W / 8;
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(ROWS * COLS - 1);
  localparam logic [1:0]        LAST_BYTE = 2'(NBYTES - 1);
  localparam logic [3:0]        STOP_BIT  = 4'd9;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_RD, LOAD, SEND, NEXT, DELIM, FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   elem_q, elem_d;
  logic [7:0]          byte_q, byte_d;
  logic [3:0]          bit_q, bit_d;       // 0 start, 1..8 data, 9 stop
  logic [BAUD_W-1:0]   baud_q, baud_d;     // down-counter, bit ends at 0
  logic [1:0]          bidx_q, bidx_d;     // byte index within element
  logic                abort_pend_q, abort_pend_d;

`ifdef MAT_TX_ROW_DELIM_EN
  localparam int             COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  logic [COL_W-1:0] col_q, col_d;
`endif

  logic bit_end, frame_end, abort_now, last_byte;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      elem_q       <= '0;
      byte_q       <= '0;
      bit_q        <= '0;
      baud_q       <= '0;
      bidx_q       <= '0;
      abort_pend_q <= 1'b0;
`ifdef MAT_TX_ROW_DELIM_EN
      col_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      elem_q       <= elem_d;
      byte_q       <= byte_d;
      bit_q        <= bit_d;
      baud_q       <= baud_d;
      bidx_q       <= bidx_d;
      abort_pend_q <= abort_pend_d;
`ifdef MAT_TX_ROW_DELIM_EN
      col_q        <= col_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    elem_d       = elem_q;
    byte_d       = byte_q;
    bit_d        = bit_q;
    baud_d       = baud_q;
    bidx_d       = bidx_q;
    abort_pend_d = abort_pend_q;
`ifdef MAT_TX_ROW_DELIM_EN
    col_d        = col_q;
`endif
    bit_end   = (baud_q == '0);
    frame_end = bit_end && (bit_q == STOP_BIT);
    // abort is a level, but a short pulse mid-byte must still be honoured
    abort_now = abort_i || abort_pend_q;
    last_byte = (bidx_q == LAST_BYTE);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d      = FETCH;
          idx_d        = '0;
          cnt_d        = '0;
          abort_pend_d = 1'b0;
`ifdef MAT_TX_ROW_DELIM_EN
          col_d        = '0;
`endif
        end
      end
      FETCH: state_d = abort_i ? FINISH : WAIT_RD;
      WAIT_RD: begin
        elem_d  = rd_data_i;
        state_d = abort_i ? FINISH : LOAD;
      end
      LOAD: begin
        if (abort_i) begin
          state_d = FINISH;
        end else begin
          byte_d  = elem_q[DATA_W-1 -: 8];
          elem_d  = elem_q << 8;
          bidx_d  = '0;
          bit_d   = '0;
          baud_d  = BAUD_MAX;
          state_d = SEND;
        end
      end
`ifdef MAT_TX_ROW_DELIM_EN
      SEND, DELIM: begin
`else
      SEND: begin
`endif
        if (abort_i) abort_pend_d = 1'b1;
        if (!bit_end) begin
          baud_d = baud_q - BAUD_W'(1);
        end else begin
          baud_d = BAUD_MAX;
          if (!frame_end) begin
            bit_d = bit_q + 4'd1;
            if (bit_q != 4'd0) byte_d = byte_q >> 1;
          end else if (abort_now) begin
            state_d = FINISH;
            // the element (or its delimiter) went out completely
            if (state_q == DELIM || last_byte) cnt_d = cnt_q + ADDR_W'(1);
          end else if (state_q == SEND && !last_byte) begin
            byte_d = elem_q[DATA_W-1 -: 8];
            elem_d = elem_q << 8;
            bidx_d = bidx_q + 2'd1;
            bit_d  = '0;
          end
`ifdef MAT_TX_ROW_DELIM_EN
          else if (state_q == SEND && col_q == LAST_COL) begin
            byte_d  = 8'h0A;
            bit_d   = '0;
            state_d = DELIM;
          end
`endif
          else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (abort_i || idx_q == LAST_IDX) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = FETCH;
`ifdef MAT_TX_ROW_DELIM_EN
          col_d   = (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
`endif
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_en_o      = (state_q == FETCH);
  assign rd_addr_o    = idx_q;
  assign busy_o       = (state_q != IDLE) && (state_q != FINISH);
  assign done_o       = (state_q == FINISH);
  assign elem_count_o = cnt_q;

  // Decoded from registered state so the async reset drives the line high
  // immediately, without waiting for an edge.
  always_comb begin
    tx_data_o = 1'b1;
    if (state_q == SEND || state_q == DELIM) begin
      if (bit_q == 4'd0)          tx_data_o = 1'b0;
      else if (bit_q != STOP_BIT) tx_data_o = byte_q[0];
    end
  end

endmodule

// File: tb/tb_mat_tx_streamer.sv
// Bench for mat_tx_streamer: a 2x2x16 instance and a 1x1x8 instance at
// 4 clocks per bit. Expected UART bytes are queued by the stimulus and
// popped by per-line receiver processes.
module tb_mat_tx_streamer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 2x2, 16-bit instance
  logic        start16, abort16, rd_en16, tx16, busy16, done16;
  logic [5:0]  rd_addr16, cnt16;
  logic [15:0] rd_data16;
  logic [15:0] mem16 [4];

  mat_tx_streamer #(.ROWS(2), .COLS(2), .DATA_W(16), .ADDR_W(6), .CLKS_PER_BIT(4)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .abort_i(abort16),
    .rd_en_o(rd_en16), .rd_addr_o(rd_addr16), .rd_data_i(rd_data16),
    .tx_data_o(tx16), .busy_o(busy16), .done_o(done16), .elem_count_o(cnt16));

  // 1x1, 8-bit instance
  logic        start8, abort8, rd_en8, tx8, busy8, done8;
  logic [5:0]  rd_addr8, cnt8;
  logic [7:0]  rd_data8;

  mat_tx_streamer #(.ROWS(1), .COLS(1), .DATA_W(8), .ADDR_W(6), .CLKS_PER_BIT(4)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .abort_i(abort8),
    .rd_en_o(rd_en8), .rd_addr_o(rd_addr8), .rd_data_i(rd_data8),
    .tx_data_o(tx8), .busy_o(busy8), .done_o(done8), .elem_count_o(cnt8));

  always @(posedge clk) begin
    if (rd_en16) rd_data16 <= mem16[rd_addr16[1:0]];
    if (rd_en8)  rd_data8  <= (rd_addr8 == 6'd0) ? 8'h5A : 8'hEE;
  end

  int done_tot16 = 0;
  int rd_tot16   = 0;
  always @(negedge clk) begin
    if (done16)  done_tot16++;
    if (rd_en16) rd_tot16++;
  end

  logic [7:0] exp16_q [$];
  logic [7:0] exp8_q  [$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic tx_sel(input bit sel);
    return sel ? tx8 : tx16;
  endfunction

  // Called on the first negedge that sees a start bit; samples mid-bit.
  task automatic rx_frame(input bit sel, output logic [7:0] b, output logic stop, output logic bad);
    bad = 1'b0;
    repeat (2) @(negedge clk);
    if (tx_sel(sel) !== 1'b0 || !rst_n) bad = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = tx_sel(sel);
      if (!rst_n) bad = 1'b1;
    end
    repeat (4) @(negedge clk);
    stop = tx_sel(sel);
    if (!rst_n) bad = 1'b1;
  endtask

  always begin : mon16
    logic [7:0] b, e;
    logic stop, bad;
    @(negedge clk);
    if (rst_n && tx16 === 1'b0) begin
      rx_frame(1'b0, b, stop, bad);
      if (!bad) begin
        if (exp16_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL byte16: got unexpected %h", b);
        end else begin
          e = exp16_q.pop_front();
          chk("byte16", {stop, b}, {1'b1, e});
        end
      end
    end
  end

  always begin : mon8
    logic [7:0] b, e;
    logic stop, bad;
    @(negedge clk);
    if (rst_n && tx8 === 1'b0) begin
      rx_frame(1'b1, b, stop, bad);
      if (!bad) begin
        if (exp8_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL byte8: got unexpected %h", b);
        end else begin
          e = exp8_q.pop_front();
          chk("byte8", {stop, b}, {1'b1, e});
        end
      end
    end
  end

  task automatic push_stream16();
    exp16_q.push_back(8'h12); exp16_q.push_back(8'h34);
    exp16_q.push_back(8'hAB); exp16_q.push_back(8'hCD);
`ifdef MAT_TX_ROW_DELIM_EN
    exp16_q.push_back(8'h0A);
`endif
    exp16_q.push_back(8'h00); exp16_q.push_back(8'h01);
    exp16_q.push_back(8'hFF); exp16_q.push_back(8'h00);
`ifdef MAT_TX_ROW_DELIM_EN
    exp16_q.push_back(8'h0A);
`endif
  endtask

  task automatic wait_done16(input string nm);
    int i = 0;
    while (done16 !== 1'b1 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk({nm, "_done_seen"}, {31'd0, done16}, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin : stim
    int d0, r0, i;
    mem16[0] = 16'h1234; mem16[1] = 16'hABCD; mem16[2] = 16'h0001; mem16[3] = 16'hFF00;
    start16 = 1'b0; abort16 = 1'b0; start8 = 1'b0; abort8 = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx",    {31'd0, tx16},   32'd1);
    chk("rst_busy",  {31'd0, busy16}, 32'd0);
    chk("rst_done",  {31'd0, done16}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_en16}, 32'd0);
    chk("rst_addr",  {26'd0, rd_addr16}, 32'd0);
    chk("rst_count", {26'd0, cnt16}, 32'd0);
    chk("rst_tx8",   {31'd0, tx8},    32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // abort in IDLE has no effect
    abort16 = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_abort_busy", {31'd0, busy16}, 32'd0);
    chk("idle_abort_done", {31'd0, done16}, 32'd0);
    abort16 = 1'b0;

    // full stream with start-to-first-start-bit latency
    push_stream16();
    d0 = done_tot16; r0 = rd_tot16;
    @(negedge clk) start16 = 1'b1;
    @(posedge clk); #1 start16 = 1'b0;
    chk("fetch_busy",  {31'd0, busy16},  32'd1);
    chk("fetch_rd_en", {31'd0, rd_en16}, 32'd1);
    chk("fetch_addr",  {26'd0, rd_addr16}, 32'd0);
    @(posedge clk); #1;
    chk("wait_rd_en",  {31'd0, rd_en16}, 32'd0);
    @(posedge clk); #1;
    chk("load_tx",     {31'd0, tx16}, 32'd1);
    @(posedge clk); #1;
    chk("first_start", {31'd0, tx16}, 32'd0);
    wait_done16("full");
    repeat (5) @(negedge clk);
    chk("full_done_cnt", done_tot16 - d0, 32'd1);
    chk("full_rd_cnt",   rd_tot16 - r0,   32'd4);
    chk("full_count",    {26'd0, cnt16},  32'd4);
    chk("full_busy",     {31'd0, busy16}, 32'd0);
    chk("full_addr_hold", {26'd0, rd_addr16}, 32'd3);

    // abort during the 2nd bit of 0xAB
    exp16_q.push_back(8'h12); exp16_q.push_back(8'h34); exp16_q.push_back(8'hAB);
    d0 = done_tot16; r0 = rd_tot16;
    @(negedge clk) start16 = 1'b1;
    @(posedge clk); #1 start16 = 1'b0;
    chk("count_cleared", {26'd0, cnt16}, 32'd0);
    repeat (96) @(posedge clk);
    #1 abort16 = 1'b1;
    @(posedge clk); #1 abort16 = 1'b0;
    wait_done16("abort");
    repeat (50) @(negedge clk);
    chk("abort_done_cnt", done_tot16 - d0, 32'd1);
    chk("abort_rd_cnt",   rd_tot16 - r0,   32'd2);
    chk("abort_count",    {26'd0, cnt16},  32'd1);

    // start and abort together: start wins, abort then ends it from FETCH
    d0 = done_tot16; r0 = rd_tot16;
    @(negedge clk) begin start16 = 1'b1; abort16 = 1'b1; end
    @(negedge clk) start16 = 1'b0;
    chk("sa_busy", {31'd0, busy16}, 32'd1);
    @(negedge clk) abort16 = 1'b0;
    chk("sa_done", {31'd0, done16}, 32'd1);
    repeat (3) @(negedge clk);
    chk("sa_done_cnt", done_tot16 - d0, 32'd1);
    chk("sa_rd_cnt",   rd_tot16 - r0,   32'd1);
    chk("sa_count",    {26'd0, cnt16},  32'd0);

    // reset during the start bit of 0x34
    exp16_q.push_back(8'h12);
    @(negedge clk) start16 = 1'b1;
    @(posedge clk); #1 start16 = 1'b0;
    repeat (44) @(posedge clk);
    #2;
    chk("pre_rst_tx", {31'd0, tx16}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx",    {31'd0, tx16},   32'd1);
    chk("async_rst_busy",  {31'd0, busy16}, 32'd0);
    chk("async_rst_count", {26'd0, cnt16},  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_rst_idle", {31'd0, busy16}, 32'd0);
    push_stream16();
    @(negedge clk) start16 = 1'b1;
    @(posedge clk); #1 start16 = 1'b0;
    chk("replay_addr", {26'd0, rd_addr16}, 32'd0);
    wait_done16("replay");
    repeat (5) @(negedge clk);
    chk("replay_count", {26'd0, cnt16}, 32'd4);

    // start held high for the whole stream
    push_stream16();
    d0 = done_tot16; r0 = rd_tot16;
    @(negedge clk) start16 = 1'b1;
    wait_done16("held");
    start16 = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_done_cnt", done_tot16 - d0, 32'd1);
    chk("held_rd_cnt",   rd_tot16 - r0,   32'd4);
    chk("held_busy",     {31'd0, busy16}, 32'd0);

    // 1x1 8-bit instance: single 0x5A frame
    exp8_q.push_back(8'h5A);
`ifdef MAT_TX_ROW_DELIM_EN
    exp8_q.push_back(8'h0A);
`endif
    @(negedge clk) start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("d8_load_tx",     {31'd0, tx8}, 32'd1);
    @(posedge clk); #1;
    chk("d8_first_start", {31'd0, tx8}, 32'd0);
    i = 0;
    while (done8 !== 1'b1 && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk("d8_done_seen", {31'd0, done8}, 32'd1);
    chk("d8_count", {26'd0, cnt8}, 32'd1);

    repeat (20) @(negedge clk);
    chk("exp16_drained", exp16_q.size(), 32'd0);
    chk("exp8_drained",  exp8_q.size(),  32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
